// File: rtl/ram1_loader.sv
// ram1_loader: packs an 8-bit valid/ready byte stream into 24-bit words (big-endian)
// and writes them to consecutive RAM1 addresses starting at BASE_ADDR, then raises done.
module ram1_loader #(
    parameter logic [19:0] BASE_ADDR = 20'd0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [23:0] RAM1_D,
    output logic [19:0] RAM1_A,
    output logic        RAM1_WE,
    output logic        RAM1_OE,
    output logic [19:0] word_count,
    output logic        done,
    output logic        overflow
);

    // 21 bits so a capacity of exactly 2^20 words is representable.
    localparam logic [20:0] MaxWords = 21'(MAX_WORDS);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [19:0] addr_q, addr_d;
    logic [19:0] word_count_q, word_count_d;
    logic        overflow_q, overflow_d;
    logic        last_q, last_d;

    logic [20:0] count_inc;
    logic        full;

    assign count_inc = {1'b0, word_count_q} + 21'd1;
    assign full      = (count_inc == MaxWords);

    // Outputs decoded from registered state only.
    assign in_ready   = (state_q == StCollect);
    assign RAM1_WE    = (state_q == StWrite);
    assign RAM1_D     = (state_q == StWrite) ? word_q : 24'd0;
    assign RAM1_A     = addr_q;
    assign RAM1_OE    = 1'b0;
    assign word_count = word_count_q;
    assign done       = (state_q == StDone);
    assign overflow   = overflow_q;

    // Next-state logic: arming, byte packing and word write bookkeeping.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        last_d       = last_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StCollect;
                    word_d       = 24'd0;
                    byte_idx_d   = 2'd0;
                    addr_d       = BASE_ADDR;
                    word_count_d = 20'd0;
                    overflow_d   = 1'b0;
                    last_d       = 1'b0;
                end
            end
            StCollect: begin
                if (in_valid && in_ready) begin
                    case (byte_idx_q)
                        2'd0:    word_d[23:16] = in_data;
                        2'd1:    word_d[15:8]  = in_data;
                        default: word_d[7:0]   = in_data;
                    endcase
                    if (byte_idx_q == 2'd2 || in_last) begin
                        state_d = StWrite;
                        last_d  = in_last;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                // Saturate rather than wrap when capacity is exactly 2^20 words.
                word_count_d = count_inc[20] ? 20'hFFFFF : count_inc[19:0];
                word_d       = 24'd0;
                byte_idx_d   = 2'd0;
                last_d       = 1'b0;
                // Hold addr on the final word so it never passes the last valid address.
                if (!full) begin
                    addr_d = addr_q + 20'd1;
                end
                if (last_q) begin
                    state_d = StDone;
                end else if (full) begin
                    state_d    = StDone;
                    overflow_d = 1'b1;
                end else begin
                    state_d = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            word_q       <= 24'd0;
            byte_idx_q   <= 2'd0;
            addr_q       <= BASE_ADDR;
            word_count_q <= 20'd0;
            overflow_q   <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_ram1_loader.sv
// Bench for ram1_loader: three instances (default, MAX_WORDS=2, BASE_ADDR=0x100),
// a packing model feeding a write scoreboard, a vector table and hand-written sequences.
module tb_ram1_loader;

    localparam logic [19:0] BASES [3] = '{20'd0, 20'd0, 20'h100};
    localparam int unsigned MAXES [3] = '{1024, 2, 1024};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s    [3];
    logic [7:0]  in_data_s  [3];
    logic        in_valid_s [3];
    logic        in_last_s  [3];
    logic        in_ready_s [3];
    logic [23:0] d_s        [3];
    logic [19:0] a_s        [3];
    logic        we_s       [3];
    logic        oe_s       [3];
    logic [19:0] wc_s       [3];
    logic        done_s     [3];
    logic        ovf_s      [3];

    int checks = 0;
    int errors = 0;

    // Model state and write scoreboard {instance, addr, data}.
    logic [23:0] m_word [3];
    int          m_idx  [3];
    logic [19:0] m_addr [3];
    logic [45:0] sb [$];
    logic        we_prev [3];

    typedef struct {
        int          n;
        logic [23:0] bytes;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram1_loader #(
            .BASE_ADDR(BASES[g]),
            .MAX_WORDS(MAXES[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[g]),
            .in_data   (in_data_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_last   (in_last_s[g]),
            .in_ready  (in_ready_s[g]),
            .RAM1_D    (d_s[g]),
            .RAM1_A    (a_s[g]),
            .RAM1_WE   (we_s[g]),
            .RAM1_OE   (oe_s[g]),
            .word_count(wc_s[g]),
            .done      (done_s[g]),
            .overflow  (ovf_s[g])
        );
    end

    // Write monitor: every WE pulse must match the scoreboard head and last one cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (we_s[i]) begin
                checks++;
                if (we_prev[i]) begin
                    errors++;
                    $display("FAIL we_pulse inst %0d: WE high %0d cycles, required 1", i, 2);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL write inst %0d: got %0h@%0h, required no write", i,
                             d_s[i], a_s[i]);
                end else begin
                    logic [45:0] e;
                    e = sb.pop_front();
                    if ({2'(i), a_s[i], d_s[i]} !== e) begin
                        errors++;
                        $display("FAIL write: got inst %0d %0h@%0h, required inst %0d %0h@%0h",
                                 i, d_s[i], a_s[i], e[45:44], e[23:0], e[43:24]);
                    end
                end
            end
            we_prev[i] = we_s[i];
        end
    end

    task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model(int s);
        m_idx[s]  = 0;
        m_word[s] = 24'd0;
    endtask

    task automatic do_start(int s, bit arm);
        start_s[s] = 1'b1;
        tick();
        start_s[s] = 1'b0;
        if (arm) begin
            clear_model(s);
            m_addr[s] = BASES[s];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) clear_model(i);
    endtask

    // Offers one byte for up to budget cycles; updates the model when accepted.
    task automatic send_byte(int s, logic [7:0] b, bit last, int budget, output bit acc);
        in_data_s[s]  = b;
        in_last_s[s]  = last;
        in_valid_s[s] = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < budget && !acc; k++) begin
            @(negedge clk);
            if (in_ready_s[s]) acc = 1'b1;
        end
        tick();
        in_valid_s[s] = 1'b0;
        in_last_s[s]  = 1'b0;
        if (acc) begin
            m_word[s] = m_word[s] | (24'(b) << (8 * (2 - m_idx[s])));
            if (m_idx[s] == 2 || last) begin
                sb.push_back({2'(s), m_addr[s], m_word[s]});
                m_addr[s] = m_addr[s] + 20'd1;
                clear_model(s);
            end else begin
                m_idx[s]++;
            end
        end
    endtask

    task automatic send(int s, logic [7:0] b, bit last);
        bit acc;
        send_byte(s, b, last, 20, acc);
        chk("byte_accepted", 48'(acc), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        tbl[0] = '{n: 2, bytes: 24'hAABBCC, exp: 24'hAABB00};
        tbl[1] = '{n: 3, bytes: 24'h010203, exp: 24'h010203};
        tbl[2] = '{n: 1, bytes: 24'hFF5A5A, exp: 24'hFF0000};
        tbl[3] = '{n: 3, bytes: 24'hDEADBE, exp: 24'hDEADBE};
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 0; in_data_s[i] = 0; in_valid_s[i] = 0; in_last_s[i] = 0;
            we_prev[i] = 0;
            clear_model(i);
            m_addr[i] = BASES[i];
        end
        tick();
        tick();
        rst = 1'b0;

        // Reset values.
        chk("rst_in_ready", 48'(in_ready_s[0]), 48'd0);
        chk("rst_we", 48'(we_s[0]), 48'd0);
        chk("rst_d", 48'(d_s[0]), 48'd0);
        chk("rst_a", 48'(a_s[0]), 48'd0);
        chk("rst_a_base100", 48'(a_s[2]), 48'h100);
        chk("rst_oe", 48'(oe_s[0]), 48'd0);
        chk("rst_wc", 48'(wc_s[0]), 48'd0);
        chk("rst_done", 48'(done_s[0]), 48'd0);
        chk("rst_ovf", 48'(ovf_s[0]), 48'd0);

        // Two full words, last on the sixth byte.
        do_start(0, 1);
        chk("t1_ready_after_start", 48'(in_ready_s[0]), 48'd1);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0);
        send(0, 8'h44, 0); send(0, 8'h55, 0); send(0, 8'h66, 1);
        chk("t1_we", 48'(we_s[0]), 48'd1);
        chk("t1_done_early", 48'(done_s[0]), 48'd0);
        tick();
        chk("t1_done", 48'(done_s[0]), 48'd1);
        chk("t1_wc", 48'(wc_s[0]), 48'd2);
        chk("t1_ovf", 48'(ovf_s[0]), 48'd0);
        chk("t1_oe", 48'(oe_s[0]), 48'd0);

        // Packing table: each entry is a one-word load ending with in_last.
        for (int i = 0; i < 4; i++) begin
            do_start(0, 1);
            chk("tbl_done_cleared", 48'(done_s[0]), 48'd0);
            chk("tbl_wc_cleared", 48'(wc_s[0]), 48'd0);
            for (int j = 0; j < tbl[i].n; j++)
                send(0, tbl[i].bytes[23 - 8 * j -: 8], j == tbl[i].n - 1);
            chk("tbl_we", 48'(we_s[0]), 48'd1);
            chk("tbl_data", 48'(d_s[0]), 48'(tbl[i].exp));
            chk("tbl_addr", 48'(a_s[0]), 48'd0);
            tick();
            chk("tbl_done", 48'(done_s[0]), 48'd1);
            chk("tbl_ovf", 48'(ovf_s[0]), 48'd0);
            chk("tbl_wc", 48'(wc_s[0]), 48'd1);
        end

        // Overflow at MAX_WORDS=2 without in_last.
        do_start(1, 1);
        for (int j = 0; j < 6; j++) send(1, 8'(8'h10 + j), 0);
        tick();
        chk("ovf_in_ready", 48'(in_ready_s[1]), 48'd0);
        chk("ovf_done", 48'(done_s[1]), 48'd1);
        chk("ovf_flag", 48'(ovf_s[1]), 48'd1);
        chk("ovf_wc", 48'(wc_s[1]), 48'd2);
        chk("ovf_addr_limit", 48'(a_s[1]), 48'd1);
        for (int j = 0; j < 3; j++) begin
            send_byte(1, 8'(8'h20 + j), 0, 5, acc);
            chk("ovf_not_accepted", 48'(acc), 48'd0);
        end

        // 30 bytes with random valid gaps into BASE_ADDR=0x100.
        do_start(2, 1);
        for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(2, 8'($urandom), j == 29);
        end
        tick();
        chk("gap_wc", 48'(wc_s[2]), 48'd10);
        chk("gap_done", 48'(done_s[2]), 48'd1);
        chk("gap_ovf", 48'(ovf_s[2]), 48'd0);

        // Reset mid-load after 4 bytes, then restart with an ignored mid-word start.
        do_start(2, 1);
        send(2, 8'hA1, 0); send(2, 8'hA2, 0); send(2, 8'hA3, 0); send(2, 8'hA4, 0);
        do_reset();
        chk("mid_rst_in_ready", 48'(in_ready_s[2]), 48'd0);
        chk("mid_rst_we", 48'(we_s[2]), 48'd0);
        chk("mid_rst_d", 48'(d_s[2]), 48'd0);
        chk("mid_rst_a", 48'(a_s[2]), 48'h100);
        chk("mid_rst_wc", 48'(wc_s[2]), 48'd0);
        chk("mid_rst_done", 48'(done_s[2]), 48'd0);
        chk("mid_rst_ovf", 48'(ovf_s[2]), 48'd0);
        do_start(2, 1);
        send(2, 8'hB1, 0);
        do_start(2, 0);
        send(2, 8'hB2, 0);
        send(2, 8'hB3, 1);
        chk("restart_we", 48'(we_s[2]), 48'd1);
        chk("restart_addr", 48'(a_s[2]), 48'h100);
        chk("restart_data", 48'(d_s[2]), 48'hB1B2B3);
        tick();
        chk("restart_wc", 48'(wc_s[2]), 48'd1);
        chk("restart_done", 48'(done_s[2]), 48'd1);

        // start together with rst: reset wins, loader stays idle.
        rst = 1'b1;
        start_s[2] = 1'b1;
        tick();
        rst = 1'b0;
        start_s[2] = 1'b0;
        clear_model(2);
        chk("rst_start_ready", 48'(in_ready_s[2]), 48'd0);
        chk("rst_start_done", 48'(done_s[2]), 48'd0);
        tick();
        chk("rst_start_idle", 48'(in_ready_s[2]), 48'd0);

        chk("sb_empty", 48'(sb.size()), 48'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram1_loader.md
# ram1_loader

Fills the 24-bit-wide RAM1 sample memory that the nearest-neighbour search engine reads. Accepts an 8-bit valid/ready byte stream and packs every three bytes into one 24-bit word. Writes the words to consecutive RAM1 addresses starting at `BASE_ADDR`, then raises `done` so the search controller can be started. It is the write side of the RAM1 interface; the search path only reads RAM1.

## Interface
- `BASE_ADDR`, default 20'd0: first RAM1 address written.
- `MAX_WORDS`, default 20'd1024: capacity in words; valid range 1..2^20-BASE_ADDR.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; arms a new load (ignored while loading).
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data`/`in_last` valid.
- `in_last`  in  1  marks final byte of the load.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `RAM1_D`  out  24  write data.
- `RAM1_A`  out  20  write address.
- `RAM1_WE`  out  1  write enable, active-high, one cycle per word.
- `RAM1_OE`  out  1  tied 0 (loader never reads).
- `word_count`  out  20  words written in the current/last load.
- `done`  out  1  load finished; held until next `start` or `rst`.
- `overflow`  out  1  load stopped at `MAX_WORDS` without seeing `in_last`.

## Operation
- States: IDLE, COLLECT, WRITE, DONE. Reset → IDLE.
- IDLE: `in_ready`=0. `start` → COLLECT; clears `word_count`, `byte_idx`, `overflow`; sets `addr`=BASE_ADDR.
- COLLECT: `in_ready`=1. A byte is accepted when `in_valid && in_ready`.
  - Byte 0 goes to bits [23:16], byte 1 to [15:8], byte 2 to [7:0]. Packing is big-endian.
  - On accepting byte 2, or any byte with `in_last`=1: go to WRITE. Unfilled lower bytes are zero.
  - Otherwise `byte_idx` increments.
- WRITE (one cycle): `RAM1_WE`=1, `RAM1_A`=`addr`, `RAM1_D`=packed word, `in_ready`=0.
  - `word_count` and `addr` increment; the word register and `byte_idx` clear.
  - Next state is DONE if the word was marked last.
  - Next state is DONE with `overflow`=1 if the new `word_count` == `MAX_WORDS`.
  - Otherwise next state is COLLECT.
  - If the last word exactly fills `MAX_WORDS`, the state goes to DONE with `overflow`=0.
- DONE: `done`=1, `in_ready`=0. `start` → COLLECT and re-arms as from IDLE, clearing `done` the next cycle.
- `start` in COLLECT or WRITE is ignored.
- `rst` mid-load abandons the partial word; RAM contents already written are untouched.
- `rst` asserted together with `start`: `rst` wins.
- `addr` never exceeds BASE_ADDR+MAX_WORDS-1. `word_count` width is 20 bits and does not wrap.
- Outside WRITE: `RAM1_WE`=0, `RAM1_D`=0, `RAM1_A`=`addr`.

## Timing
- Reset values: `in_ready`=0, `RAM1_WE`=0, `RAM1_D`=0, `RAM1_A`=BASE_ADDR, `RAM1_OE`=0, `word_count`=0, `done`=0, `overflow`=0.
- `start` sampled in cycle N → `in_ready`=1 in cycle N+1.
- Completing byte accepted in cycle N → `RAM1_WE`=1 in cycle N+1 → `in_ready`=1 again in N+2.
- Peak throughput is 3 bytes per 4 cycles.
- `word_count` shows the new value in cycle N+2.
- `done` and `overflow` rise in the cycle after the final WRITE, i.e. N+2.
- `in_ready`, `RAM1_WE` and `done` are decoded from registered state only; there is no combinational path from `in_valid`.
- An `in_valid` gap of any length mid-word preserves the partial word.

## Test plan
- Start, then bytes 0x11,0x22,0x33,0x44,0x55,0x66 (last on 0x66) → writes 0x112233@0, 0x445566@1; `word_count`=2; `done`=1 two cycles after 0x66.
- Bytes 0xAA,0xBB with `in_last` on 0xBB → single write 0xAABB00@0; `overflow`=0.
- `MAX_WORDS`=2, feed 9 bytes without `in_last` → two writes; after the 6th byte `in_ready`=0, `done`=1, `overflow`=1; bytes 7–9 are never accepted.
- Random `in_valid` gaps with 30 bytes, `BASE_ADDR`=20'h100 → 10 writes at 0x100..0x109 with correct packing; each `RAM1_WE` pulse is 1 cycle.
- `rst` after 4 bytes → all outputs at reset values next cycle. Restart with 3 bytes → write lands at BASE_ADDR, not BASE_ADDR+1.
- `start` during COLLECT is ignored. `start` in DONE clears `done` and `word_count`. `start`+`rst` in the same cycle → IDLE.
